// File: rtl/tdc_multihit_packer_pkg.sv
// Shared types and width helpers for the multi-hit TDC packer.
// The entry layout and overflow code follow the default configuration.
package tdc_pkg;
  function automatic int fw_of(input int nph);
    return $clog2(nph);
  endfunction

  function automatic int iw_of(input int nspad);
    return $clog2(nspad + 1);
  endfunction

  function automatic int nw_of(input int max_hits);
    return $clog2(max_hits + 1);
  endfunction

  localparam int DEF_NPH        = 32;
  localparam int DEF_CW         = 10;
  localparam int DEF_NSPAD      = 16;
  localparam int DEF_MAX_HITS   = 3;
  localparam int DEF_WINDOW_CYC = 1023;
  localparam int DEF_FW         = fw_of(DEF_NPH);
  localparam int DEF_DW         = DEF_CW + DEF_FW;
  localparam int DEF_IW         = iw_of(DEF_NSPAD);

  // Sent as the data word of the single beat of an empty window
  localparam logic [DEF_DW-1:0] OVF_CODE = '1;

  typedef enum logic [1:0] {IDLE, ARMED, DRAIN, DONE} tdc_state_e;

  typedef struct packed {
    logic [DEF_CW-1:0] coarse;
    logic [DEF_FW-1:0] fine;
    logic [DEF_IW-1:0] intensity;
  } hit_entry_t;
endpackage

// File: rtl/tdc_multihit_packer_if.sv
// Hit capture inputs and valid/ready frame output of the multi-hit TDC packer.
interface tdc_multihit_packer_if import tdc_pkg::*; #(
  parameter int NPH      = DEF_NPH,
  parameter int CW       = DEF_CW,
  parameter int NSPAD    = DEF_NSPAD,
  parameter int MAX_HITS = DEF_MAX_HITS
);
  localparam int FW = fw_of(NPH);
  localparam int DW = CW + FW;
  localparam int IW = iw_of(NSPAD);
  localparam int NW = nw_of(MAX_HITS);

  logic             TDC_start;
  logic             hit_valid;
  logic [NPH-1:0]   hit_phase;
  logic [NSPAD-1:0] hit_spaden;
  logic [IW-1:0]    int_thresh;
  logic [DW-1:0]    TDC_Odata;
  logic [IW-1:0]    TDC_Oint;
  logic [NW-1:0]    TDC_Onum;
  logic             TDC_Olast;
  logic             TDC_Ovalid;
  logic             TDC_Oready;
  logic             TDC_INT;
  logic             TDC_drop;
  logic             TDC_bubble;
  logic             busy;

  modport master (
    output TDC_start, hit_valid, hit_phase, hit_spaden, int_thresh, TDC_Oready,
    input  TDC_Odata, TDC_Oint, TDC_Onum, TDC_Olast, TDC_Ovalid, TDC_INT,
           TDC_drop, TDC_bubble, busy
  );

  modport slave (
    input  TDC_start, hit_valid, hit_phase, hit_spaden, int_thresh, TDC_Oready,
    output TDC_Odata, TDC_Oint, TDC_Onum, TDC_Olast, TDC_Ovalid, TDC_INT,
           TDC_drop, TDC_bubble, busy
  );
endinterface

// File: rtl/tdc_therm_decoder.sv
// Thermometer-style DLL phase decoder: index of the lowest 0->1 edge (circular).
// All-zeros / all-ones words have no edge and are flagged as bubbles.
module tdc_therm_decoder import tdc_pkg::*; #(
  parameter  int NPH = DEF_NPH,
  localparam int FW  = fw_of(NPH)
) (
  input  logic [NPH-1:0] phase,
  output logic [FW-1:0]  fine,
  output logic           bubble
);
  always_comb begin
    fine   = '0;
    bubble = 1'b1;
    // Scan downward so the lowest matching index is the one left standing
    for (int i = NPH - 1; i >= 0; i--) begin
      if (phase[i] && !phase[(i + NPH - 1) % NPH]) begin
        fine   = FW'(i);
        bubble = 1'b0;
      end
    end
  end
endmodule

// File: rtl/tdc_multihit_packer.sv
// Time-stamps up to MAX_HITS thresholded SPAD hits per window and drains them
// as one valid/ready frame, followed by a one-cycle interrupt.
module tdc_multihit_packer import tdc_pkg::*; #(
  parameter int NPH        = DEF_NPH,
  parameter int CW         = DEF_CW,
  parameter int NSPAD      = DEF_NSPAD,
  parameter int MAX_HITS   = DEF_MAX_HITS,
  parameter int WINDOW_CYC = DEF_WINDOW_CYC
) (
  input logic clk,
  input logic rst,
  tdc_multihit_packer_if.slave bus
);
  localparam int FW = fw_of(NPH);
  localparam int IW = iw_of(NSPAD);
  localparam int NW = nw_of(MAX_HITS);

  tdc_state_e     state;
  logic [CW-1:0]  coarse;
  hit_entry_t     buffer [MAX_HITS];
  logic [NW-1:0]  cnt, rd;
  logic           ovalid, int_q, drop_q, bubble_q;
  logic [FW-1:0]  fine;
  logic           phase_bubble;
  logic [IW-1:0]  popcnt;
  logic           accept, window_end, last;

  tdc_therm_decoder #(.NPH(NPH)) u_dec (
    .phase  (bus.hit_phase),
    .fine   (fine),
    .bubble (phase_bubble)
  );

  always_comb begin
    popcnt = '0;
    for (int i = 0; i < NSPAD; i++) popcnt += IW'(bus.hit_spaden[i]);
  end

  assign accept     = bus.hit_valid && (popcnt >= bus.int_thresh);
  assign window_end = (coarse == CW'(WINDOW_CYC - 1));
  assign last       = (cnt == '0) || (rd == cnt - 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      coarse   <= '0;
      cnt      <= '0;
      rd       <= '0;
      ovalid   <= 1'b0;
      int_q    <= 1'b0;
      drop_q   <= 1'b0;
      bubble_q <= 1'b0;
    end else begin
      int_q <= 1'b0;
      case (state)
        IDLE: if (bus.TDC_start) begin
          state    <= ARMED;
          coarse   <= '0;
          cnt      <= '0;
          drop_q   <= 1'b0;
          bubble_q <= 1'b0;
        end
        ARMED: begin
          if (bus.TDC_start) begin
            // Restart: hit in this cycle belongs to no window
            coarse   <= '0;
            cnt      <= '0;
            drop_q   <= 1'b0;
            bubble_q <= 1'b0;
          end else begin
            coarse <= coarse + 1'b1;
            if (accept) begin
              if (cnt < NW'(MAX_HITS)) begin
                buffer[cnt] <= '{coarse: coarse, fine: fine, intensity: popcnt};
                cnt         <= cnt + 1'b1;
                if (phase_bubble) bubble_q <= 1'b1;
              end else begin
                drop_q <= 1'b1;
              end
            end
            if (window_end) begin
              state  <= DRAIN;
              rd     <= '0;
              ovalid <= 1'b1;
            end
          end
        end
        DRAIN: if (bus.TDC_Oready) begin
          if (last) begin
            state  <= DONE;
            ovalid <= 1'b0;
            int_q  <= 1'b1;
          end else begin
            rd <= rd + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.TDC_Ovalid = ovalid;
  assign bus.TDC_Odata  = !ovalid     ? '0 :
                          (cnt == '0) ? OVF_CODE :
                                        {buffer[rd].coarse, buffer[rd].fine};
  assign bus.TDC_Oint   = (ovalid && cnt != '0) ? buffer[rd].intensity : '0;
  assign bus.TDC_Onum   = ovalid ? cnt : '0;
  assign bus.TDC_Olast  = ovalid && last;
  assign bus.TDC_INT    = int_q;
  assign bus.TDC_drop   = drop_q;
  assign bus.TDC_bubble = bubble_q;
  assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_tdc_multihit_packer.sv
// Self-checking bench: directed and random windows against a queue-based frame model.
module tb_tdc_multihit_packer;
  localparam int WIN = 1023;
  localparam int MAXH = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tdc_multihit_packer_if bus_i ();
  tdc_multihit_packer dut (.clk(clk), .rst(rst), .bus(bus_i));

  int n_chk = 0;
  int n_err = 0;

  int          hit_off [$];
  logic [31:0] hit_ph  [$];
  logic [15:0] hit_sp  [$];
  bit          stall_mode;
  bit          start_in_drain;
  logic [14:0] got_d0;
  logic [4:0]  got_i0;
  logic        got_drop, got_bub;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void decode(input logic [31:0] p, output logic [4:0] f, output bit bub);
    f   = '0;
    bub = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (bub && p[i] && !p[(i + 31) % 32]) begin
        f   = 5'(i);
        bub = 1'b0;
      end
    end
  endfunction

  task automatic add_hit(input int off, input logic [31:0] ph, input logic [15:0] sp);
    hit_off.push_back(off);
    hit_ph.push_back(ph);
    hit_sp.push_back(sp);
  endtask

  task automatic clear_hits();
    hit_off.delete();
    hit_ph.delete();
    hit_sp.delete();
  endtask

  task automatic run_window();
    logic [14:0] exp_d [$];
    logic [4:0]  exp_i [$];
    bit          drop_e = 0, bub_e = 0;
    int          nbeats, beat, cyc;
    bit          prev_stall = 0;
    logic [14:0] pd;
    logic [4:0]  pi;
    logic [1:0]  pn;
    logic        pl, rdy;

    bus_i.TDC_start = 1'b1;
    tick();
    bus_i.TDC_start = 1'b0;
    chk("busy_armed", bus_i.busy, 1);
    for (int k = 1; k <= WIN; k++) begin
      for (int j = 0; j < hit_off.size(); j++) begin
        if (hit_off[j] == k) begin
          logic [4:0] f;
          bit         b;
          int         pc;
          bus_i.hit_valid  = 1'b1;
          bus_i.hit_phase  = hit_ph[j];
          bus_i.hit_spaden = hit_sp[j];
          pc = $countones(hit_sp[j]);
          if (pc >= int'(bus_i.int_thresh)) begin
            if (exp_d.size() < MAXH) begin
              decode(hit_ph[j], f, b);
              exp_d.push_back({10'(k - 1), f});
              exp_i.push_back(5'(pc));
              if (b) bub_e = 1;
            end else begin
              drop_e = 1;
            end
          end
        end
      end
      tick();
      bus_i.hit_valid = 1'b0;
    end
    chk("ovalid_rise", bus_i.TDC_Ovalid, 1);

    if (exp_d.size() == 0) begin
      exp_d.push_back(15'h7FFF);
      exp_i.push_back(5'd0);
      nbeats = 1;
    end else begin
      nbeats = exp_d.size();
    end

    beat = 0;
    cyc  = 0;
    while (beat < nbeats && cyc < 300) begin
      rdy = stall_mode ? (cyc >= 8 && cyc[0]) : ($urandom_range(0, 3) != 0);
      bus_i.TDC_Oready = rdy;
      if (start_in_drain && cyc == 3) bus_i.TDC_start = 1'b1;
      if (prev_stall) begin
        chk("stall_data", bus_i.TDC_Odata, pd);
        chk("stall_int",  bus_i.TDC_Oint,  pi);
        chk("stall_num",  bus_i.TDC_Onum,  pn);
        chk("stall_last", bus_i.TDC_Olast, pl);
      end
      if (bus_i.TDC_Ovalid && rdy) begin
        if (beat == 0) begin
          got_d0 = bus_i.TDC_Odata;
          got_i0 = bus_i.TDC_Oint;
        end
        chk("beat_data", bus_i.TDC_Odata, exp_d[beat]);
        chk("beat_int",  bus_i.TDC_Oint,  exp_i[beat]);
        chk("beat_num",  bus_i.TDC_Onum,  (nbeats == 1 && exp_d[0] == 15'h7FFF && exp_i[0] == 0
                                           && hit_off.size() == 0) ? 0 : 32'(exp_d.size()));
        chk("beat_last", bus_i.TDC_Olast, (beat == nbeats - 1) ? 1 : 0);
        beat++;
        prev_stall = 0;
      end else begin
        chk("valid_in_drain", bus_i.TDC_Ovalid, 1);
        prev_stall = bus_i.TDC_Ovalid;
      end
      pd = bus_i.TDC_Odata;
      pi = bus_i.TDC_Oint;
      pn = bus_i.TDC_Onum;
      pl = bus_i.TDC_Olast;
      tick();
      bus_i.TDC_start = 1'b0;
      cyc++;
    end
    if (beat < nbeats) chk("drain_timeout", beat, nbeats);
    bus_i.TDC_Oready = 1'b0;

    chk("done_int",    bus_i.TDC_INT,    1);
    chk("done_valid",  bus_i.TDC_Ovalid, 0);
    chk("done_busy",   bus_i.busy,       1);
    chk("done_drop",   bus_i.TDC_drop,   drop_e);
    chk("done_bubble", bus_i.TDC_bubble, bub_e);
    got_drop = bus_i.TDC_drop;
    got_bub  = bus_i.TDC_bubble;
    tick();
    chk("idle_int",    bus_i.TDC_INT,    0);
    chk("idle_busy",   bus_i.busy,       0);
    chk("idle_valid",  bus_i.TDC_Ovalid, 0);
    chk("hold_drop",   bus_i.TDC_drop,   drop_e);
    chk("hold_bubble", bus_i.TDC_bubble, bub_e);
  endtask

  // Windows with no stored hit but some rejected ones still report Onum=0
  // through the empty-frame path; beat_num above only special-cases the
  // literally hitless window, so directed empty windows use no hits.

  initial begin
    bus_i.TDC_start  = 1'b0;
    bus_i.hit_valid  = 1'b0;
    bus_i.hit_phase  = '0;
    bus_i.hit_spaden = '0;
    bus_i.int_thresh = '0;
    bus_i.TDC_Oready = 1'b0;
    stall_mode     = 0;
    start_in_drain = 0;
    repeat (3) tick();
    chk("rst_valid",  bus_i.TDC_Ovalid, 0);
    chk("rst_data",   bus_i.TDC_Odata,  0);
    chk("rst_int",    bus_i.TDC_INT,    0);
    chk("rst_busy",   bus_i.busy,       0);
    chk("rst_drop",   bus_i.TDC_drop,   0);
    chk("rst_bubble", bus_i.TDC_bubble, 0);
    rst = 1'b0;
    tick();

    // single hit
    clear_hits();
    add_hit(10, 32'h0003FFFC, 16'h00F1);
    run_window();
    chk("t1_data", got_d0, 15'h122);
    chk("t1_int",  got_i0, 5);

    // overflow of the hit buffer
    clear_hits();
    add_hit(5, 32'h00000F00, 16'h0001);
    add_hit(20, 32'h80000001, 16'h0003);
    add_hit(40, 32'h0000FFFF, 16'h0007);
    add_hit(60, 32'h000000F0, 16'h000F);
    run_window();
    chk("t2_drop", got_drop, 1);

    // empty window
    clear_hits();
    run_window();
    chk("t3_data", got_d0, 15'h7FFF);

    // threshold filtering and bubble
    bus_i.int_thresh = 5'd6;
    clear_hits();
    add_hit(3, 32'h0003FFFC, 16'h00F1);
    add_hit(7, 32'h0003FFFC, 16'h0FF1);
    add_hit(9, 32'hFFFFFFFF, 16'h0FF1);
    run_window();
    chk("t4_int",    got_i0, 9);
    chk("t4_bubble", got_bub, 1);
    bus_i.int_thresh = 5'd0;

    // back-pressure with start pulsed mid-drain
    stall_mode = 1;
    start_in_drain = 1;
    clear_hits();
    add_hit(100, 32'h00FF0000, 16'hFFFF);
    add_hit(900, 32'h0000001E, 16'h0101);
    run_window();
    stall_mode = 0;
    start_in_drain = 0;

    // reset mid-window aborts the frame
    begin
      int bad = 0;
      bus_i.TDC_start = 1'b1;
      tick();
      bus_i.TDC_start = 1'b0;
      for (int k = 1; k <= 30; k++) begin
        bus_i.hit_valid  = (k == 5 || k == 9);
        bus_i.hit_phase  = 32'h000000F0;
        bus_i.hit_spaden = 16'h00FF;
        tick();
      end
      bus_i.hit_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy",  bus_i.busy,       0);
      chk("abort_valid", bus_i.TDC_Ovalid, 0);
      bus_i.TDC_Oready = 1'b1;
      for (int k = 0; k < 1100; k++) begin
        if (bus_i.TDC_Ovalid || bus_i.TDC_INT || bus_i.busy) bad++;
        tick();
      end
      bus_i.TDC_Oready = 1'b0;
      chk("abort_quiet", bad, 0);
    end
    clear_hits();
    add_hit(2, 32'h00000002, 16'h0003);
    run_window();
    chk("fresh_data", got_d0, {10'd1, 5'd1});

    // random windows
    for (int w = 0; w < 5; w++) begin
      int nh;
      clear_hits();
      bus_i.int_thresh = 5'($urandom_range(0, 8));
      nh = $urandom_range(1, 5);
      while (hit_off.size() < nh) begin
        int off;
        bit dup;
        logic [31:0] ph;
        int r;
        off = $urandom_range(1, WIN);
        dup = 0;
        foreach (hit_off[j]) if (hit_off[j] == off) dup = 1;
        if (!dup) begin
          r = $urandom_range(0, 9);
          if (r == 0)      ph = '0;
          else if (r == 1) ph = '1;
          else begin
            int s, len;
            s   = $urandom_range(0, 31);
            len = $urandom_range(1, 31);
            ph  = '0;
            for (int j = 0; j < len; j++) ph[(s + j) % 32] = 1'b1;
          end
          add_hit(off, ph, 16'($urandom()));
        end
      end
      // guarantee at least one stored hit so the frame is not the empty code
      add_hit(1, 32'h00000001, 16'hFFFF);
      run_window();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/tdc_multihit_packer.md
Name: tdc_multihit_packer

Overview:
Parametrised multi-hit successor of the single-shot TDC output stage. It time-stamps up to MAX_HITS SPAD hits per measurement window using an internal coarse counter and a fine code decoded from the sampled DLL phase word. Hits below a programmable intensity threshold are filtered out. Each window's results are emitted as one valid/ready frame carrying data, intensity, hit count and last, followed by an interrupt pulse. It sits between the synchronised SPAD/DLL capture logic and the core-logic readout.

Parameters:
NPH, 32, number of DLL phases; fine width FW = $clog2(NPH)
CW, 10, coarse counter width; data width DW = CW+FW
NSPAD, 16, SPAD enables per pixel; intensity width IW = $clog2(NSPAD+1)
MAX_HITS, 3, hit buffer depth per window; count width NW = $clog2(MAX_HITS+1)
WINDOW_CYC, 1023, window length in clk cycles; must be ≤ 2^CW

Ports:
clk  in  1  logic clock; all inputs are synchronous to it
rst  in  1  synchronous reset, active-high
TDC_start  in  1  single-cycle pulse that opens a measurement window
hit_valid  in  1  single-cycle pulse, a hit is present this cycle
hit_phase  in  NPH  DLL phase snapshot at the hit
hit_spaden  in  NSPAD  SPAD enables at the hit
int_thresh  in  IW  minimum intensity to accept a hit (0 accepts all)
TDC_Odata  out  DW  {coarse, fine}
TDC_Oint  out  IW  popcount of hit_spaden
TDC_Onum  out  NW  number of stored hits in the frame
TDC_Olast  out  1  final beat of the frame
TDC_Ovalid  out  1  output beat valid
TDC_Oready  in  1  downstream ready
TDC_INT  out  1  one-cycle pulse after the frame completes
TDC_drop  out  1  sticky per window: a hit was lost because the buffer was full
TDC_bubble  out  1  sticky per window: a stored hit had an undecodable phase
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, buffer count 0, coarse counter 0. Reset mid-window or mid-drain aborts immediately with no frame and no interrupt.
- States: IDLE, ARMED, DRAIN, DONE.
- IDLE: on TDC_start go to ARMED. Clear buffer, TDC_drop and TDC_bubble. Coarse counter reads 0 in the first ARMED cycle. A hit_valid in the same cycle as start is ignored.
- ARMED: coarse counter increments every cycle. A hit_valid presented k cycles after start has coarse = k-1.
- Hit acceptance: a hit is accepted when popcount(hit_spaden) ≥ int_thresh. If the buffer holds fewer than MAX_HITS entries, the hit is stored. If the buffer is full, the hit is not stored and TDC_drop is set.
- Fine decode: fine = smallest i for which hit_phase[i]=1 and hit_phase[(i-1) mod NPH]=0. If the word is all 0s or all 1s, fine = 0 and TDC_bubble is set.
- Window end: when the counter equals WINDOW_CYC-1, go to DRAIN. A hit in that cycle is still accepted.
- TDC_start during ARMED restarts the window: buffer, counter and flags are cleared. A coincident hit is ignored.
- DRAIN:
  - TDC_Ovalid rises in the first DRAIN cycle.
  - Stored entries are output oldest first. TDC_Onum = stored count on every beat. TDC_Olast=1 on the final beat.
  - With zero stored hits, one beat is sent: Odata = all ones (overflow code), Oint = 0, Onum = 0, Olast = 1.
  - While Ovalid=1 and Oready=0, Odata, Oint, Onum and Olast hold stable.
  - A beat advances only on Ovalid & Oready.
  - TDC_start is ignored in DRAIN and DONE.
- DONE: entered the cycle after the last handshake, with Ovalid=0. TDC_INT=1 for exactly that one cycle. Next cycle returns to IDLE. TDC_drop and TDC_bubble hold until the next start or reset.

Decomposition:
- Package tdc_pkg holds:
  - the state enum
  - the width helper functions for FW, IW and NW
  - the overflow-code constant
  - the packed hit-entry struct {coarse, fine, intensity}
- Sub-module tdc_therm_decoder (NPH): takes hit_phase, produces fine and bubble; purely combinational.
- The popcount stays inline.

Test Plan:
- Defaults, int_thresh=0. Start, then hit 10 cycles later with phase 32'h0003FFFC, spaden 16'h00F1 -> one beat: Odata=0x122 (coarse 9, fine 2), Oint=5, Onum=1, Olast=1; TDC_INT one cycle after the handshake.
- Hits at cycles 5, 20, 40, 60 after start (4 hits, MAX_HITS=3) -> three beats with coarse 4, 19, 39, each Onum=3; Olast on the third; TDC_drop=1.
- Start with no hits -> after 1023 cycles one beat: Odata=15'h7FFF, Oint=0, Onum=0, Olast=1; then TDC_INT.
- int_thresh=6. Hits with spaden 16'h00F1 (5) and 16'h0FF1 (9) -> only the second is stored, Oint=9, Onum=1. Phase 32'hFFFFFFFF on a further hit -> TDC_bubble=1, fine=0.
- Two stored hits, TDC_Oready held low 8 cycles then toggled -> outputs stable while stalled; exactly two handshakes; TDC_start pulsed mid-drain has no effect.
- rst pulsed mid-ARMED with 2 stored hits -> no frame, no TDC_INT, busy=0. A following start behaves as a fresh window.
